// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled serial receiver with optional parity, one-deep output holding register.
// Latency: rx_valid 1 clk after the mid-stop-bit tick; no backpressure on rx, an unread word is overwritten and overrun pulses.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    localparam int             BW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  LAST_BIT = BW'(DATA_BITS - 1);
    localparam logic           PAR_EN   = (PARITY_EN != 0);
    localparam logic           PAR_ODD  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_nx;
    logic [3:0]            tick_cnt, tick_cnt_nx;
    logic [BW-1:0]         bit_cnt, bit_cnt_nx;
    logic [DATA_BITS-1:0]  shreg, shreg_nx;
    logic                  perr, perr_nx;
    logic                  done, ferr;
    logic                  rx_meta, rx_s;

    // Line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            perr     <= 1'b0;
        end else begin
            state    <= state_nx;
            tick_cnt <= tick_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
            perr     <= perr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        tick_cnt_nx = tick_cnt;
        bit_cnt_nx  = bit_cnt;
        shreg_nx    = shreg;
        perr_nx     = perr;
        done        = 1'b0;
        ferr        = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx    = START;
                        tick_cnt_nx = '0;
                    end
                end
                START: begin
                    tick_cnt_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd7) begin
                        if (!rx_s) begin
                            state_nx    = DATA;
                            tick_cnt_nx = '0;
                            bit_cnt_nx  = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end
                end
                DATA: begin
                    tick_cnt_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        shreg_nx    = {rx_s, shreg[DATA_BITS-1:1]};
                        tick_cnt_nx = '0;
                        if (bit_cnt == LAST_BIT) begin
                            state_nx = PAR_EN ? PARITY : STOP;
                        end else begin
                            bit_cnt_nx = bit_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    tick_cnt_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        perr_nx     = (^shreg) ^ rx_s ^ PAR_ODD;
                        tick_cnt_nx = '0;
                        state_nx    = STOP;
                    end
                end
                STOP: begin
                    tick_cnt_nx = tick_cnt + 4'd1;
                    if (tick_cnt == 4'd15) begin
                        // Back to IDLE now so a start bit right after the stop bit is caught next tick.
                        ferr        = ~rx_s;
                        done        = 1'b1;
                        tick_cnt_nx = '0;
                        state_nx    = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                rx_data    <= shreg;
                frame_err  <= ferr;
                parity_err <= PAR_EN & perr;
                rx_valid   <= 1'b1;
                overrun    <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench: dut0 has no parity, dut1 has even parity; each has its own serial line.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick = 1'b0;
    logic       rx0, rx1, rdy0, rdy1;
    logic [7:0] rx_data0, rx_data1;
    logic       rx_valid0, rx_valid1, frame_err0, frame_err1;
    logic       parity_err0, parity_err1, overrun0, overrun1;

    int tests = 0;
    int fails = 0;
    int div   = 0;
    int ovr0  = 0;
    int ovr1  = 0;
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    always #5 clk = ~clk;

    // One tick every 4 clocks, changed on the falling edge.
    always @(negedge clk) begin
        tick <= (div == 3);
        div  <= (div == 3) ? 0 : div + 1;
    end

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx0),
        .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ready(rdy0),
        .frame_err(frame_err0), .parity_err(parity_err0), .overrun(overrun0)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .rx(rx1),
        .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ready(rdy1),
        .frame_err(frame_err1), .parity_err(parity_err1), .overrun(overrun1)
    );

    // Record every accepted word as {parity_err, frame_err, data} and count overrun cycles.
    always @(posedge clk) begin
        if (!reset) begin
            if (rx_valid0 && rdy0) q0.push_back({parity_err0, frame_err0, rx_data0});
            if (rx_valid1 && rdy1) q1.push_back({parity_err1, frame_err1, rx_data1});
            if (overrun0) ovr0++;
            if (overrun1) ovr1++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        int c = 0;
        while (c < n) begin
            @(posedge clk);
            if (tick) c++;
        end
        #1;
    endtask

    task automatic send_bit(input bit sel, input logic b);
        if (sel) rx1 = b;
        else     rx0 = b;
        wait_ticks(16);
    endtask

    task automatic send_head(input bit sel, input logic [7:0] d, input bit has_par, input logic par);
        send_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
        if (has_par) send_bit(sel, par);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop);
        send_head(sel, d, has_par, par);
        send_bit(sel, stop);
        if (sel) rx1 = 1'b1;
        else     rx0 = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        rx0   = 1'b1;
        rx1   = 1'b1;
        rdy0  = 1'b0;
        rdy1  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_data0",   32'(rx_data0),    32'h0);
        chk("reset_valid0",  32'(rx_valid0),   32'h0);
        chk("reset_ferr0",   32'(frame_err0),  32'h0);
        chk("reset_perr0",   32'(parity_err0), 32'h0);
        chk("reset_ovr0",    32'(overrun0),    32'h0);
        chk("reset_valid1",  32'(rx_valid1),   32'h0);
        chk("reset_perr1",   32'(parity_err1), 32'h0);
        reset = 1'b0;

        wait_ticks(40);
        chk("idle_valid0", 32'(rx_valid0), 32'h0);
        chk("idle_count0", 32'(q0.size()), 32'd0);

        // Two back-to-back frames with the consumer always ready.
        rdy0 = 1'b1;
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        chk("basic_count", 32'(q0.size()), 32'd2);
        chk("basic_w0",    32'(q0[0]),     32'h0A5);
        chk("basic_w1",    32'(q0[1]),     32'h03C);
        chk("basic_ovr",   32'(ovr0),      32'd0);

        // Low pulse shorter than half a bit must be rejected.
        rx0 = 1'b0;
        wait_ticks(5);
        rx0 = 1'b1;
        wait_ticks(32);
        chk("glitch_count", 32'(q0.size()), 32'd2);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        chk("glitch_next_count", 32'(q0.size()), 32'd3);
        chk("glitch_next_w",     32'(q0[2]),     32'h055);

        // Stop bit low; word held with frame_err set.
        rdy0 = 1'b0;
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
        wait_ticks(32);
        chk("ferr_valid", 32'(rx_valid0),  32'h1);
        chk("ferr_data",  32'(rx_data0),   32'h81);
        chk("ferr_flag",  32'(frame_err0), 32'h1);
        chk("ferr_count", 32'(q0.size()),  32'd3);

        // Reset in the middle of a frame while a word is held.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(rx_valid0),  32'h0);
        chk("midrst_data",  32'(rx_data0),   32'h0);
        chk("midrst_ferr",  32'(frame_err0), 32'h0);
        rx0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        wait_ticks(200);
        chk("midrst_idle_valid", 32'(rx_valid0), 32'h0);
        chk("midrst_idle_count", 32'(q0.size()), 32'd3);

        // Overrun: nothing consumed across two frames.
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_ticks(16);
        chk("ovr_pulses", 32'(ovr0),       32'd1);
        chk("ovr_data",   32'(rx_data0),   32'h22);
        chk("ovr_valid",  32'(rx_valid0),  32'h1);
        chk("ovr_count",  32'(q0.size()),  32'd3);
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        rdy0 = 1'b0;
        chk("ovr_drain_count", 32'(q0.size()), 32'd4);
        chk("ovr_drain_w",     32'(q0[3]),     32'h022);
        chk("ovr_drain_valid", 32'(rx_valid0), 32'h0);

        // Ready only in the completion cycle of the second frame (9th tick of its stop bit).
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_head(1'b0, 8'h22, 1'b0, 1'b0);
        rx0 = 1'b1;
        wait_ticks(8);
        repeat (3) @(posedge clk);
        #1;
        rdy0 = 1'b1;
        @(posedge clk);
        #1;
        rdy0 = 1'b0;
        chk("simul_valid", 32'(rx_valid0), 32'h1);
        chk("simul_data",  32'(rx_data0),  32'h22);
        chk("simul_ovr",   32'(ovr0),      32'd1);
        chk("simul_count", 32'(q0.size()), 32'd5);
        chk("simul_w",     32'(q0[4]),     32'h011);
        wait_ticks(7 + 16);
        chk("simul_ovr_after", 32'(ovr0), 32'd1);

        // Even parity: 0x07 has three ones, so parity bit 1 is correct.
        rdy1 = 1'b1;
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        wait_ticks(16);
        chk("par_ok_count", 32'(q1.size()), 32'd1);
        chk("par_ok_w",     32'(q1[0]),     32'h007);
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_ticks(16);
        chk("par_bad_count", 32'(q1.size()), 32'd2);
        chk("par_bad_w",     32'(q1[1]),     32'h207);
        chk("par_ovr",       32'(ovr1),      32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
